logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the multi-bit, multi-operation successor to the single-bit gates. Each accepted transaction carries two WIDTH-bit operands and a 3-bit opcode. The result is computed in stage 0 and travels through a STAGES-deep valid/ready pipeline with full backpressure. It sits between a stimulus source and a result sink in lab datapaths, and is the standard registered gate element for later blocks.

---
 rtl/logic_pkg.sv | 37 +++
 rtl/logic_pipe_stage.sv | 30 +++
 rtl/logic_pipe.sv | 82 ++++++++
 tb/tb_logic_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - opcode enum and width-agnostic bitwise evaluator for logic_pipe
package logic_pkg;

    localparam int EVAL_W = 64;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    // Evaluated at the widest supported width; callers keep only their low WIDTH bits.
    function automatic logic [EVAL_W-1:0] logic_eval(
        input op_e               op,
        input logic [EVAL_W-1:0] a,
        input logic [EVAL_W-1:0] b
    );
        logic [EVAL_W-1:0] y;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// rtl/logic_pipe_stage.sv - one valid/data register of the logic_pipe pipeline
module logic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_accept,
    output logic             accept,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // An empty stage always loads, so bubbles collapse even when downstream stalls.
    assign accept = !valid || next_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (accept) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - pipelined bitwise logic unit with valid/ready backpressure
module logic_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_y,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [WIDTH-1:0] eval_y;
    logic             push;
    logic             pop;

    assign eval_y = WIDTH'(logic_eval(op_e'(in_op), EVAL_W'(in_a), EVAL_W'(in_b)));

    // Per-stage signals live in each generate block so the ready chain is a set of
    // distinct nets rather than one vector feeding back on itself.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic             next_accept;
        logic             accept;
        logic             valid;
        logic [WIDTH-1:0] data;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = eval_y;
        end else begin : g_body
            assign prev_valid = g_stage[k-1].valid;
            assign prev_data  = g_stage[k-1].data;
        end

        if (k == STAGES - 1) begin : g_tail
            assign next_accept = out_ready;
        end else begin : g_link
            assign next_accept = g_stage[k+1].accept;
        end

        logic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .next_accept(next_accept),
            .accept     (accept),
            .valid      (valid),
            .data       (data)
        );
    end

    assign in_ready  = g_stage[0].accept;
    assign out_valid = g_stage[STAGES-1].valid;
    assign out_y     = g_stage[STAGES-1].data;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - scoreboard bench for logic_pipe with directed and swept random traffic
module tb_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input int op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r;
        case (op)
            0:       r = ~a;
            1:       r = a & b;
            2:       r = a | b;
            3:       r = (a | b) & ~(a & b);
            4:       r = ~a | ~b;
            5:       r = ~a & ~b;
            6:       r = (a & b) | (~a & ~b);
            default: r = a;
        endcase
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    // main 8x2 instance
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b, out_y;
    logic [1:0] occupancy;

    logic_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .occupancy(occupancy)
    );

    logic [63:0] exp_q[$];
    int          lat_q[$];
    bit          ex_q[$];
    bit          exact = 1'b0;
    int          emit_cnt = 0;

    task automatic step(input logic v, input int op, input logic [7:0] a, input logic [7:0] b,
                        input logic ordy, input logic [7:0] e, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_op     = 3'(op);
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #2;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(64'(e));
            lat_q.push_back(cyc);
            ex_q.push_back(exact);
        end
    endtask

    task automatic send(input logic v, input logic ordy, output logic acc);
        int         op;
        logic [7:0] a, b;
        op = $urandom_range(0, 7);
        a  = 8'($urandom);
        b  = 8'($urandom);
        step(v, op, a, b, ordy, 8'(ref_op(op, 64'(a), 64'(b), 8)), acc);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 0, 8'h00, 8'h00, ordy, 8'h00, acc);
    endtask

    initial begin : main_monitor
        logic       stall_prev;
        logic [7:0] y_prev;
        logic [63:0] e;
        int         l;
        bit         x;
        stall_prev = 1'b0;
        y_prev     = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_y", 64'(out_y), 64'(y_prev));
                end
                if (out_valid && out_ready) begin
                    emit_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=%0h required=none", out_y);
                    end else begin
                        e = exp_q.pop_front();
                        l = lat_q.pop_front();
                        x = ex_q.pop_front();
                        chk("out_y", 64'(out_y), e);
                        if (x) chk("latency", 64'(cyc - l), 64'd2);
                    end
                end
                stall_prev = out_valid && !out_ready;
                y_prev     = out_y;
            end
        end
    end

    // parameter sweep instances, each with its own reset, stimulus and scoreboard
    wire [5:0] sweep_done;

    for (genvar g = 0; g < 6; g++) begin : g_sw
        localparam int W  = (g < 2) ? 1 : ((g < 4) ? 33 : 64);
        localparam int S  = (g % 2 == 0) ? 1 : 4;
        localparam int OW = $clog2(S + 1);

        logic          rs, iv, ir, ov, ordy, done;
        logic [2:0]    op;
        logic [W-1:0]  a, b, y;
        logic [OW-1:0] occ;
        logic [63:0]   q[$];
        int            lq[$];
        bit            xq[$];
        bit            ex;

        logic_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rs), .in_valid(iv), .in_ready(ir), .in_op(op),
            .in_a(a), .in_b(b), .out_valid(ov), .out_ready(ordy), .out_y(y),
            .occupancy(occ)
        );

        assign sweep_done[g] = done;

        initial begin : stim
            logic [63:0] ra, rb;
            int          o;
            rs = 1'b0; iv = 1'b0; op = '0; a = '0; b = '0; ordy = 1'b1; ex = 1'b0; done = 1'b0;
            repeat (3) @(negedge clk);
            rs = 1'b1;
            for (int i = 0; i < 340; i++) begin
                @(negedge clk);
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                o  = $urandom_range(0, 7);
                ex = (i < 24);
                if (i < 24) begin
                    iv   = 1'b1;
                    ordy = 1'b1;
                    o    = i % 8;
                    ra   = ((i / 8) % 2 == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
                end else if (i < 24 + S + 2 || i >= 324) begin
                    iv   = 1'b0;
                    ordy = 1'b1;
                end else begin
                    iv   = ($urandom_range(0, 1) == 1);
                    ordy = ($urandom_range(0, 9) < 7);
                end
                op = 3'(o);
                a  = ra[W-1:0];
                b  = rb[W-1:0];
                #2;
                if (iv && ir) begin
                    q.push_back(ref_op(o, ra, rb, W));
                    lq.push_back(cyc);
                    xq.push_back(ex);
                end
            end
            chk($sformatf("sw%0d_drained", g), 64'(q.size()), 64'd0);
            done = 1'b1;
        end

        initial begin : mon
            logic         st_prev;
            logic [W-1:0] y_prev;
            logic [63:0]  e;
            int           l;
            bit           x;
            st_prev = 1'b0;
            y_prev  = '0;
            forever begin
                @(negedge clk);
                #3;
                if (!rs) begin
                    st_prev = 1'b0;
                end else begin
                    if (st_prev) chk($sformatf("sw%0d_hold_y", g), 64'(y), 64'(y_prev));
                    if (ov && ordy) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sw%0d_unexpected_out actual=%0h required=none", g, y);
                        end else begin
                            e = q.pop_front();
                            l = lq.pop_front();
                            x = xq.pop_front();
                            chk($sformatf("sw%0d_out_y", g), 64'(y), e);
                            if (x) chk($sformatf("sw%0d_latency", g), 64'(cyc - l), 64'(S));
                        end
                    end
                    st_prev = ov && !ordy;
                    y_prev  = y;
                end
            end
        end
    end

    initial begin : directed
        logic [7:0] tab [8];
        logic       acc;
        int         n_acc;
        int         e0;
        tab = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // all eight ops back-to-back
        exact = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, 8'hA5, 8'h3C, 1'b1, tab[i], acc);
            chk("ops_accept", 64'(acc), 64'd1);
        end
        repeat (4) idle(1'b1);
        chk("ops_drained", 64'(exp_q.size()), 64'd0);
        exact = 1'b0;

        // backpressure fills exactly two stages
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, acc);
            n_acc += int'(acc);
        end
        chk("bp_accepts", 64'(n_acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        send(1'b1, 1'b1, acc);
        chk("bp_ready_return", 64'(acc), 64'd1);
        repeat (4) idle(1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // bubble collapse behind a stalled output
        send(1'b1, 1'b0, acc);
        chk("bub_first", 64'(acc), 64'd1);
        repeat (3) idle(1'b0);
        send(1'b1, 1'b0, acc);
        chk("bub_second", 64'(acc), 64'd1);
        idle(1'b0);
        chk("bub_occupancy", 64'(occupancy), 64'd2);
        chk("bub_out_valid", 64'(out_valid), 64'd1);
        e0 = emit_cnt;
        idle(1'b1);
        idle(1'b1);
        #2;
        chk("bub_consecutive", 64'(emit_cnt - e0), 64'd2);
        chk("bub_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset with a full pipeline
        send(1'b1, 1'b0, acc);
        send(1'b1, 1'b0, acc);
        idle(1'b0);
        chk("mid_occupancy", 64'(occupancy), 64'd2);
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        ex_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_y", 64'(out_y), 64'd0);
        chk("mid_rst_occupancy", 64'(occupancy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exact = 1'b1;
        step(1'b1, 0, 8'h00, 8'h5A, 1'b1, 8'hFF, acc);
        chk("post_rst_accept", 64'(acc), 64'd1);
        repeat (3) idle(1'b1);
        chk("post_rst_drained", 64'(exp_q.size()), 64'd0);
        exact = 1'b0;

        for (int i = 0; i < 20000 && sweep_done != 6'h3F; i++) @(negedge clk);
        chk("sweep_done", 64'(sweep_done), 64'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
